// File: rtl/lock_pkg.sv
// Shared encodings and widths for the combination-lock sequencing controller.
package lock_pkg;

   localparam int unsigned STATE_W  = 3;
   localparam int unsigned REMAIN_W = 4;
   localparam int unsigned FAIL_W   = 3;

   // Encoding doubles as the display state code.
   typedef enum logic [STATE_W-1:0] {
      ST_LOCKED  = 3'd0,
      ST_CHECK   = 3'd1,
      ST_OPEN    = 3'd2,
      ST_SET_PWD = 3'd3,
      ST_ALARM   = 3'd4
   } state_e;

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: a registered one-cycle tick each TICK_DIV clocks, restartable.
module sec_tick #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CNT_W = $clog2(TICK_DIV);

   logic [CNT_W-1:0] cnt;

   // tick is registered one count early so it is high exactly while cnt == TICK_DIV-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (restart) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= (cnt == CNT_W'(TICK_DIV - 2));
         cnt  <= (cnt == CNT_W'(TICK_DIV - 1)) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/lock_ctrl.sv
// Combination-lock sequencer: locked / check / open / set-password / alarm lockout.
module lock_ctrl
   import lock_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 50_000_000,
   parameter int unsigned OPEN_SEC    = 5,
   parameter int unsigned LOCKOUT_SEC = 10,
   parameter int unsigned MAX_FAIL    = 3,
   parameter int unsigned CMP_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enter_trig,
   input  logic                init_trig,
   input  logic                cmp_valid,
   input  logic                cmp_match,
   output logic                unlock,
   output logic                alarm,
   output logic                pwd_load,
   output logic                err_pulse,
   output logic [FAIL_W-1:0]   fail_cnt,
   output logic [STATE_W-1:0]  state_code,
   output logic [REMAIN_W-1:0] remain_sec
);

   localparam int unsigned WAIT_W = 8;

   state_e              state, state_nxt;
   logic [REMAIN_W-1:0] remain_nxt;
   logic [FAIL_W-1:0]   fail_nxt;
   logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
   logic                pwd_load_nxt, err_nxt;
   logic                restart_c, tick;

   // Prescaler phase restarts on every state change so each countdown gets full seconds.
   assign restart_c = (state_nxt != state);

   sec_tick #(.TICK_DIV(TICK_DIV)) u_sec_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart_c),
      .tick    (tick)
   );

   assign state_code = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_LOCKED;
         remain_sec <= '0;
         fail_cnt   <= '0;
         wait_cnt   <= '0;
         unlock     <= 1'b0;
         alarm      <= 1'b0;
         pwd_load   <= 1'b0;
         err_pulse  <= 1'b0;
      end else begin
         state      <= state_nxt;
         remain_sec <= remain_nxt;
         fail_cnt   <= fail_nxt;
         wait_cnt   <= wait_nxt;
         unlock     <= (state_nxt == ST_OPEN) || (state_nxt == ST_SET_PWD);
         alarm      <= (state_nxt == ST_ALARM);
         pwd_load   <= pwd_load_nxt;
         err_pulse  <= err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      remain_nxt   = remain_sec;
      fail_nxt     = fail_cnt;
      wait_nxt     = wait_cnt;
      pwd_load_nxt = 1'b0;
      err_nxt      = 1'b0;

      unique case (state)
         ST_LOCKED: begin
            if (enter_trig) begin
               state_nxt = ST_CHECK;
               wait_nxt  = '0;
            end
         end

         ST_CHECK: begin
            wait_nxt = wait_cnt + 1'b1;
            if (cmp_valid && cmp_match) begin
               state_nxt  = ST_OPEN;
               fail_nxt   = '0;
               remain_nxt = REMAIN_W'(OPEN_SEC);
            end else if (cmp_valid || (wait_cnt == WAIT_W'(CMP_TIMEOUT - 1))) begin
               err_nxt  = 1'b1;
               fail_nxt = (fail_cnt < FAIL_W'(MAX_FAIL)) ? fail_cnt + 1'b1 : fail_cnt;
               if (fail_nxt == FAIL_W'(MAX_FAIL)) begin
                  state_nxt  = ST_ALARM;
                  remain_nxt = REMAIN_W'(LOCKOUT_SEC);
               end else begin
                  state_nxt = ST_LOCKED;
               end
            end
         end

         ST_OPEN: begin
            if (enter_trig) begin
               state_nxt  = ST_LOCKED;
               remain_nxt = '0;
            end else if (init_trig) begin
               state_nxt  = ST_SET_PWD;
               remain_nxt = REMAIN_W'(OPEN_SEC);
            end else if (tick) begin
               remain_nxt = remain_sec - 1'b1;
               if (remain_sec == REMAIN_W'(1)) state_nxt = ST_LOCKED;
            end
         end

         ST_SET_PWD: begin
            if (enter_trig) begin
               state_nxt    = ST_LOCKED;
               remain_nxt   = '0;
               pwd_load_nxt = 1'b1;
            end else if (init_trig) begin
               state_nxt  = ST_LOCKED;
               remain_nxt = '0;
            end else if (tick) begin
               remain_nxt = remain_sec - 1'b1;
               if (remain_sec == REMAIN_W'(1)) state_nxt = ST_LOCKED;
            end
         end

         ST_ALARM: begin
            if (tick) begin
               remain_nxt = remain_sec - 1'b1;
               if (remain_sec == REMAIN_W'(1)) begin
                  state_nxt = ST_LOCKED;
                  fail_nxt  = '0;
               end
            end
         end

         default: state_nxt = ST_LOCKED;
      endcase
   end

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl with short timing parameters.
module tb_lock_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enter_trig, init_trig, cmp_valid, cmp_match;
   logic       unlock, alarm, pwd_load, err_pulse;
   logic [2:0] fail_cnt, state_code;
   logic [3:0] remain_sec;

   int n_checks = 0;
   int n_fail   = 0;

   lock_ctrl #(
      .TICK_DIV    (4),
      .OPEN_SEC    (3),
      .LOCKOUT_SEC (2),
      .MAX_FAIL    (3),
      .CMP_TIMEOUT (5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enter_trig (enter_trig),
      .init_trig  (init_trig),
      .cmp_valid  (cmp_valid),
      .cmp_match  (cmp_match),
      .unlock     (unlock),
      .alarm      (alarm),
      .pwd_load   (pwd_load),
      .err_pulse  (err_pulse),
      .fail_cnt   (fail_cnt),
      .state_code (state_code),
      .remain_sec (remain_sec)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then settle 1ns past the edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic open_lock();
      enter_trig = 1'b1;
      cyc(1);
      enter_trig = 1'b0;
      cmp_valid  = 1'b1;
      cmp_match  = 1'b1;
      cyc(1);
      cmp_valid  = 1'b0;
      cmp_match  = 1'b0;
   endtask

   task automatic wrong_entry();
      enter_trig = 1'b1;
      cyc(1);
      enter_trig = 1'b0;
      cyc(1);
      cmp_valid  = 1'b1;
      cmp_match  = 1'b0;
      cyc(1);
      cmp_valid  = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      enter_trig = 1'b0;
      init_trig  = 1'b0;
      cmp_valid  = 1'b0;
      cmp_match  = 1'b0;
      #2;
      check("rst_state", int'(state_code), 0);
      check("rst_outs", int'({unlock, alarm, pwd_load, err_pulse, fail_cnt, remain_sec}), 0);
      #10 rst_n = 1'b1;
      cyc(1);

      // Correct code then auto-relock after 3 seconds of 4 clocks
      enter_trig = 1'b1;
      cyc(1);
      enter_trig = 1'b0;
      check("t1_check_state", int'(state_code), 1);
      cyc(1);
      cmp_valid = 1'b1;
      cmp_match = 1'b1;
      cyc(1);
      cmp_valid = 1'b0;
      cmp_match = 1'b0;
      check("t1_open_state", int'(state_code), 2);
      check("t1_unlock", int'(unlock), 1);
      check("t1_remain3", int'(remain_sec), 3);
      cyc(4);
      check("t1_remain2", int'(remain_sec), 2);
      cyc(4);
      check("t1_remain1", int'(remain_sec), 1);
      cyc(3);
      check("t1_still_open", int'(state_code), 2);
      cyc(1);
      check("t1_relock_state", int'(state_code), 0);
      check("t1_relock_unlock", int'(unlock), 0);
      check("t1_relock_remain", int'(remain_sec), 0);

      // Three wrong entries -> alarm lockout
      for (int i = 1; i <= 3; i++) begin
         wrong_entry();
         check($sformatf("t2_err_%0d", i), int'(err_pulse), 1);
         check($sformatf("t2_fail_%0d", i), int'(fail_cnt), i);
         check($sformatf("t2_state_%0d", i), int'(state_code), (i == 3) ? 4 : 0);
         check($sformatf("t2_alarm_%0d", i), int'(alarm), (i == 3) ? 1 : 0);
         if (i < 3) cyc(1);
      end
      check("t2_remain2", int'(remain_sec), 2);
      cyc(1);
      check("t2_err_clear", int'(err_pulse), 0);
      enter_trig = 1'b1;
      cmp_valid  = 1'b1;
      cmp_match  = 1'b1;
      cyc(1);
      enter_trig = 1'b0;
      cmp_valid  = 1'b0;
      cmp_match  = 1'b0;
      check("t2_ignore_state", int'(state_code), 4);
      cyc(5);
      check("t2_alarm_hold", int'(alarm), 1);
      check("t2_remain1", int'(remain_sec), 1);
      cyc(1);
      check("t2_end_alarm", int'(alarm), 0);
      check("t2_end_fail", int'(fail_cnt), 0);
      check("t2_end_state", int'(state_code), 0);

      // Two wrong entries then a correct one
      wrong_entry();
      cyc(1);
      wrong_entry();
      check("t3_fail2", int'(fail_cnt), 2);
      cyc(1);
      open_lock();
      check("t3_fail0", int'(fail_cnt), 0);
      check("t3_unlock", int'(unlock), 1);
      check("t3_alarm", int'(alarm), 0);
      enter_trig = 1'b1;
      cyc(1);
      enter_trig = 1'b0;
      check("t3_manual_relock", int'(state_code), 0);
      check("t3_relock_unlock", int'(unlock), 0);

      // Password change, commit
      open_lock();
      init_trig = 1'b1;
      cyc(1);
      init_trig = 1'b0;
      check("t4_setpwd_state", int'(state_code), 3);
      check("t4_setpwd_unlock", int'(unlock), 1);
      check("t4_setpwd_remain", int'(remain_sec), 3);
      check("t4_no_early_load", int'(pwd_load), 0);
      enter_trig = 1'b1;
      cyc(1);
      enter_trig = 1'b0;
      check("t4_load", int'(pwd_load), 1);
      check("t4_load_state", int'(state_code), 0);
      check("t4_load_unlock", int'(unlock), 0);
      cyc(1);
      check("t4_load_once", int'(pwd_load), 0);

      // Password change, abort via init
      open_lock();
      init_trig = 1'b1;
      cyc(1);
      check("t4b_setpwd_state", int'(state_code), 3);
      cyc(1);
      init_trig = 1'b0;
      check("t4b_abort_load", int'(pwd_load), 0);
      check("t4b_abort_state", int'(state_code), 0);

      // Simultaneous enter+init in SET_PWD loads the password
      open_lock();
      init_trig = 1'b1;
      cyc(1);
      enter_trig = 1'b1;
      cyc(1);
      enter_trig = 1'b0;
      init_trig  = 1'b0;
      check("t4c_both_load", int'(pwd_load), 1);
      check("t4c_both_state", int'(state_code), 0);

      // Compare timeout
      enter_trig = 1'b1;
      cyc(1);
      enter_trig = 1'b0;
      cyc(4);
      check("t5_no_err_yet", int'(err_pulse), 0);
      check("t5_wait_state", int'(state_code), 1);
      cyc(1);
      check("t5_err", int'(err_pulse), 1);
      check("t5_fail1", int'(fail_cnt), 1);
      check("t5_state", int'(state_code), 0);

      // Simultaneous enter+init in OPEN relocks
      open_lock();
      enter_trig = 1'b1;
      init_trig  = 1'b1;
      cyc(1);
      enter_trig = 1'b0;
      init_trig  = 1'b0;
      check("t6_both_state", int'(state_code), 0);
      check("t6_both_unlock", int'(unlock), 0);
      cyc(1);
      check("t6_no_setpwd", int'(state_code), 0);

      // Async reset mid-SET_PWD
      open_lock();
      init_trig = 1'b1;
      cyc(1);
      init_trig = 1'b0;
      check("t6_pre_rst_state", int'(state_code), 3);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_state", int'(state_code), 0);
      check("t6_rst_outs", int'({unlock, alarm, pwd_load, err_pulse, fail_cnt, remain_sec}), 0);
      enter_trig = 1'b1;
      cyc(2);
      check("t6_rst_no_load", int'(pwd_load), 0);
      enter_trig = 1'b0;
      #3 rst_n = 1'b1;
      cyc(2);
      check("t6_post_rst_state", int'(state_code), 0);
      check("t6_post_rst_load", int'(pwd_load), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
